// File: rtl/stage_decode_register_pkg.sv
// ----------------------------------------------------------------------------
// stage_decode_register_pkg
// Shared definitions for the fetch-to-decode stage: opcode constants,
// instruction field bit positions and the decode FSM state encoding.
// ----------------------------------------------------------------------------
package stage_decode_register_pkg;

   localparam int INSTR_W = 16;

   localparam logic [6:0] OPC_NOP  = 7'b0000000;
   localparam logic [6:0] OPC_LOAD = 7'b0100000;
   localparam logic [6:0] OPC_HALT = 7'b1111111;

   localparam int OPC_MSB  = 15;
   localparam int OPC_LSB  = 9;
   localparam int DST_MSB  = 8;
   localparam int DST_LSB  = 6;
   localparam int SRC0_MSB = 5;
   localparam int SRC0_LSB = 3;
   localparam int SRC1_MSB = 2;
   localparam int SRC1_LSB = 0;

   // All-zero encoding doubles as the bubble inserted on stalls and flushes.
   localparam logic [INSTR_W-1:0] NOP_INSTR = {OPC_NOP, 9'b0};

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_STALL  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

endpackage

// File: rtl/decode_hazard_unit.sv
// ----------------------------------------------------------------------------
// decode_hazard_unit
// Combinational load-use detector. Flags a hazard when the instruction held
// in the decode register is a valid LOAD whose destination is read by the
// instruction currently presented by fetch.
// Ports:
//   reg_opcode  in  opcode of the decode register
//   reg_dst     in  destination field of the decode register
//   reg_valid   in  decode register holds a real instruction
//   in_src0     in  src0 field of the incoming instruction
//   in_src1     in  src1 field of the incoming instruction
//   hazard      out load-use hazard detected
// ----------------------------------------------------------------------------
module decode_hazard_unit
   import stage_decode_register_pkg::*;
(
   input  logic [6:0] reg_opcode,
   input  logic [2:0] reg_dst,
   input  logic       reg_valid,
   input  logic [2:0] in_src0,
   input  logic [2:0] in_src1,
   output logic       hazard
);

   assign hazard = reg_valid && (reg_opcode == OPC_LOAD) &&
                   ((in_src0 == reg_dst) || (in_src1 == reg_dst));

endmodule

// File: rtl/stage_decode_register.sv
// ----------------------------------------------------------------------------
// stage_decode_register
// Fetch-to-decode pipeline register of the 16-bit-instruction core. Registers
// instruction and PC, splits the instruction into fields, inserts bubbles on
// flushes and (optionally) load-use hazards, and latches HALT into a sticky
// halt request.
//
// Build option: DECODE_HAZARD_EN -- when defined, load-use detection and the
// STALL state are built in; otherwise the PC stop only asserts in HALTED.
//
// Ports:
//   i_clk, i_rst_n          clock, async active-low reset
//   i_sys_halt              global freeze, all state holds
//   i_instruction           instruction from fetch
//   i_program_counter       PC of i_instruction
//   i_flush                 discard the instruction being captured
//   o_instruction           registered instruction (NOP on a bubble)
//   o_program_counter       registered PC
//   o_valid                 o_instruction is real, not a bubble
//   o_opcode/o_dst/o_src0/o_src1  field slices of o_instruction
//   o_program_counter_stop  combinational; fetch holds its PC this cycle
//   o_halt_req              sticky halt request
//
// state     | meaning
// ST_RUN    | normal capture, hazard check active
// ST_STALL  | one bubble inserted, capture without hazard check
// ST_HALTED | HALT decoded, everything frozen until reset
// ----------------------------------------------------------------------------
module stage_decode_register
   import stage_decode_register_pkg::*;
#(
   parameter int ADDRESS_SIZE = 10,
   parameter int DATA_SIZE    = 32
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_sys_halt,
   input  logic [INSTR_W-1:0]      i_instruction,
   input  logic [ADDRESS_SIZE-1:0] i_program_counter,
   input  logic                    i_flush,
   output logic [INSTR_W-1:0]      o_instruction,
   output logic [ADDRESS_SIZE-1:0] o_program_counter,
   output logic                    o_valid,
   output logic [6:0]              o_opcode,
   output logic [2:0]              o_dst,
   output logic [2:0]              o_src0,
   output logic [2:0]              o_src1,
   output logic                    o_program_counter_stop,
   output logic                    o_halt_req
);

   // DATA_SIZE is carried only so every stage shares one parameter set.
   if (DATA_SIZE < 1) begin : g_data_size_check
      $error("stage_decode_register: DATA_SIZE must be positive");
   end

   state_t                  state_q;
   logic [INSTR_W-1:0]      instr_q;
   logic [ADDRESS_SIZE-1:0] pc_q;
   logic                    valid_q;
   logic                    hazard;

`ifdef DECODE_HAZARD_EN
   logic hazard_raw;

   decode_hazard_unit u_hazard (
      .reg_opcode (instr_q[OPC_MSB:OPC_LSB]),
      .reg_dst    (instr_q[DST_MSB:DST_LSB]),
      .reg_valid  (valid_q),
      .in_src0    (i_instruction[SRC0_MSB:SRC0_LSB]),
      .in_src1    (i_instruction[SRC1_MSB:SRC1_LSB]),
      .hazard     (hazard_raw)
   );

   // Only checked in RUN: STALL already paid for this instruction, and a
   // flush discards the consumer anyway.
   assign hazard = hazard_raw && (state_q == ST_RUN) && !i_flush;
`else
   assign hazard = 1'b0;
`endif

   // Not gated by i_sys_halt: fetch sees the same stop value while frozen.
   assign o_program_counter_stop = (state_q == ST_HALTED) || hazard;
   assign o_halt_req             = (state_q == ST_HALTED);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_RUN;
         instr_q <= NOP_INSTR;
         pc_q    <= '0;
         valid_q <= 1'b0;
      end else if (!i_sys_halt && (state_q != ST_HALTED)) begin
         if (i_flush) begin
            instr_q <= NOP_INSTR;
            pc_q    <= i_program_counter;
            valid_q <= 1'b0;
            state_q <= ST_RUN;
         end else if (hazard) begin
            instr_q <= NOP_INSTR;
            pc_q    <= i_program_counter;
            valid_q <= 1'b0;
            state_q <= ST_STALL;
         end else begin
            instr_q <= i_instruction;
            pc_q    <= i_program_counter;
            valid_q <= 1'b1;
            state_q <= (i_instruction[OPC_MSB:OPC_LSB] == OPC_HALT) ? ST_HALTED : ST_RUN;
         end
      end
   end

   assign o_instruction     = instr_q;
   assign o_program_counter = pc_q;
   assign o_valid           = valid_q;
   assign o_opcode          = instr_q[OPC_MSB:OPC_LSB];
   assign o_dst             = instr_q[DST_MSB:DST_LSB];
   assign o_src0            = instr_q[SRC0_MSB:SRC0_LSB];
   assign o_src1            = instr_q[SRC1_MSB:SRC1_LSB];

endmodule

// File: tb/tb_stage_decode_register.sv
module tb_stage_decode_register;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_sys_halt = 1'b0;
   logic [15:0] i_instruction = 16'h0000;
   logic [9:0]  i_program_counter = 10'd0;
   logic        i_flush = 1'b0;
   logic [15:0] o_instruction;
   logic [9:0]  o_program_counter;
   logic        o_valid;
   logic [6:0]  o_opcode;
   logic [2:0]  o_dst;
   logic [2:0]  o_src0;
   logic [2:0]  o_src1;
   logic        o_program_counter_stop;
   logic        o_halt_req;

   stage_decode_register #(.ADDRESS_SIZE(10), .DATA_SIZE(32)) dut (
      .i_clk                  (i_clk),
      .i_rst_n                (i_rst_n),
      .i_sys_halt             (i_sys_halt),
      .i_instruction          (i_instruction),
      .i_program_counter      (i_program_counter),
      .i_flush                (i_flush),
      .o_instruction          (o_instruction),
      .o_program_counter      (o_program_counter),
      .o_valid                (o_valid),
      .o_opcode               (o_opcode),
      .o_dst                  (o_dst),
      .o_src0                 (o_src0),
      .o_src1                 (o_src1),
      .o_program_counter_stop (o_program_counter_stop),
      .o_halt_req             (o_halt_req)
   );

   always #5 i_clk = ~i_clk;

   localparam logic [15:0] I_A    = 16'h0A53; // opc 5, dst 1, src0 2, src1 3
   localparam logic [15:0] I_B    = 16'h0C00; // opc 6, fields 0
   localparam logic [15:0] I_LD   = 16'h4080; // LOAD r2
   localparam logic [15:0] I_USE  = 16'h0711; // opc 3, dst 4, src0 2, src1 1
   localparam logic [15:0] I_R3   = 16'h071B; // opc 3, dst 4, src0 3, src1 3
   localparam logic [15:0] I_HALT = 16'hFE00;

   typedef struct {
      logic        rst_n;
      logic        sh;
      logic        fl;
      logic [15:0] instr;
      logic [9:0]  pc;
      logic [15:0] e_instr;
      logic [9:0]  e_pc;
      logic        e_valid;
      logic        e_stop;
      logic        e_halt;
   } row_t;

   typedef struct {
      int          idx;
      logic [15:0] e_instr;
      logic [9:0]  e_pc;
      logic        e_valid;
      logic        e_stop;
      logic        e_halt;
   } exp_t;

   row_t rows[$];
   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;

   task automatic add(input logic rst_n, input logic sh, input logic fl,
                      input logic [15:0] instr, input logic [9:0] pc,
                      input logic [15:0] e_instr, input logic [9:0] e_pc,
                      input logic e_valid, input logic e_stop, input logic e_halt);
      row_t r;
      r.rst_n = rst_n; r.sh = sh; r.fl = fl; r.instr = instr; r.pc = pc;
      r.e_instr = e_instr; r.e_pc = e_pc; r.e_valid = e_valid;
      r.e_stop = e_stop; r.e_halt = e_halt;
      rows.push_back(r);
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s row%0d: got %0h expected %0h", name, idx, act, req);
      end
   endtask

   // Monitor: compares at the falling edge whenever an expectation is pending.
   initial begin
      exp_t e;
      forever begin
         @(negedge i_clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("instruction", e.idx, 32'(o_instruction), 32'(e.e_instr));
            chk("pc",          e.idx, 32'(o_program_counter), 32'(e.e_pc));
            chk("valid",       e.idx, 32'(o_valid), 32'(e.e_valid));
            chk("opcode",      e.idx, 32'(o_opcode), 32'(e.e_instr[15:9]));
            chk("dst",         e.idx, 32'(o_dst), 32'(e.e_instr[8:6]));
            chk("src0",        e.idx, 32'(o_src0), 32'(e.e_instr[5:3]));
            chk("src1",        e.idx, 32'(o_src1), 32'(e.e_instr[2:0]));
            chk("pc_stop",     e.idx, 32'(o_program_counter_stop), 32'(e.e_stop));
            chk("halt_req",    e.idx, 32'(o_halt_req), 32'(e.e_halt));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      // Reset and first stream: outputs trail inputs by one cycle.
      add(0,0,0, I_A,   10'd5,  16'h0000, 10'd0, 0,0,0);
      add(1,0,0, I_A,   10'd5,  16'h0000, 10'd0, 0,0,0);
      add(1,0,0, I_B,   10'd6,  I_A,      10'd5, 1,0,0);
      add(1,0,0, I_LD,  10'd7,  I_B,      10'd6, 1,0,0);
`ifdef DECODE_HAZARD_EN
      add(1,0,0, I_USE, 10'd8,  I_LD,     10'd7, 1,1,0);
      add(1,0,0, I_USE, 10'd8,  16'h0000, 10'd8, 0,0,0);
      add(1,0,0, I_A,   10'd9,  I_USE,    10'd8, 1,0,0);
`else
      add(1,0,0, I_USE, 10'd8,  I_LD,     10'd7, 1,0,0);
      add(1,0,0, I_A,   10'd9,  I_USE,    10'd8, 1,0,0);
`endif
      // LOAD followed by an instruction that does not read r2.
      add(1,0,0, I_LD,  10'd10, I_A,      10'd9, 1,0,0);
      add(1,0,0, I_R3,  10'd11, I_LD,     10'd10,1,0,0);
      add(1,0,0, I_B,   10'd12, I_R3,     10'd11,1,0,0);
      // Flushed HALT becomes a bubble and does not set the halt request.
      add(1,0,1, I_HALT,10'd13, I_B,      10'd12,1,0,0);
      add(1,0,0, I_A,   10'd14, 16'h0000, 10'd13,0,0,0);
      add(1,0,0, I_B,   10'd15, I_A,      10'd14,1,0,0);
      // Global freeze.
`ifdef DECODE_HAZARD_EN
      add(1,0,0, I_LD,  10'd16, I_B,      10'd15,1,0,0);
      add(1,0,0, I_USE, 10'd17, I_LD,     10'd16,1,1,0);
      add(1,1,0, I_USE, 10'd17, 16'h0000, 10'd17,0,0,0);
      add(1,1,0, I_USE, 10'd17, 16'h0000, 10'd17,0,0,0);
      add(1,1,0, I_USE, 10'd17, 16'h0000, 10'd17,0,0,0);
      add(1,0,0, I_USE, 10'd17, 16'h0000, 10'd17,0,0,0);
      add(1,0,0, I_B,   10'd18, I_USE,    10'd17,1,0,0);
`else
      add(1,0,0, I_LD,  10'd16, I_B,      10'd15,1,0,0);
      add(1,1,0, I_USE, 10'd17, I_LD,     10'd16,1,0,0);
      add(1,1,0, I_USE, 10'd17, I_LD,     10'd16,1,0,0);
      add(1,1,0, I_USE, 10'd17, I_LD,     10'd16,1,0,0);
      add(1,0,0, I_USE, 10'd17, I_LD,     10'd16,1,0,0);
      add(1,0,0, I_B,   10'd18, I_USE,    10'd17,1,0,0);
`endif
      // HALT capture, then frozen outputs while flush toggles.
      add(1,0,0, I_HALT,10'd19, I_B,      10'd18,1,0,0);
      add(1,0,1, I_A,   10'd20, I_HALT,   10'd19,1,1,1);
      for (int k = 0; k < 10; k++)
         add(1,0,logic'(k % 2), (k % 2 == 0) ? I_B : I_LD, 10'(21 + k), I_HALT, 10'd19, 1,1,1);
      // Asynchronous reset in the middle of a cycle.
      add(0,0,0, I_A,   10'd21, 16'h0000, 10'd0, 0,0,0);
      add(1,0,0, I_A,   10'd21, 16'h0000, 10'd0, 0,0,0);
      add(1,0,0, I_B,   10'd22, I_A,      10'd21,1,0,0);

      @(posedge i_clk);
      @(posedge i_clk);
      for (int n = 0; n < rows.size(); n++) begin
         @(posedge i_clk);
         #1;
         i_rst_n           = rows[n].rst_n;
         i_sys_halt        = rows[n].sh;
         i_flush           = rows[n].fl;
         i_instruction     = rows[n].instr;
         i_program_counter = rows[n].pc;
         e.idx     = n;
         e.e_instr = rows[n].e_instr;
         e.e_pc    = rows[n].e_pc;
         e.e_valid = rows[n].e_valid;
         e.e_stop  = rows[n].e_stop;
         e.e_halt  = rows[n].e_halt;
         exp_q.push_back(e);
      end
      @(negedge i_clk);
      @(negedge i_clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
